// File: rtl/letter_sequencer_pkg.sv
// Shared definitions for the letter sequencer: blank glyph code, letter codes,
// sequencer state encoding and message identifiers.
package letter_sequencer_pkg;

    localparam logic [3:0] LETTER_BLANK = 4'hF;
    localparam int         MSG_MAX_LEN  = 16;

    typedef enum logic [3:0] {
        LTR_A = 4'd0, LTR_B, LTR_C, LTR_D, LTR_E, LTR_F, LTR_G, LTR_H,
        LTR_I, LTR_J, LTR_K, LTR_L, LTR_M, LTR_N, LTR_O
    } letter_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        REVEAL = 2'd2,
        HOLD   = 2'd3
    } seq_state_t;

    // Lower id wins arbitration.
    localparam int MSG_HIGH = 0;
    localparam int MSG_OK   = 1;
    localparam int MSG_GAME = 2;
    localparam int MSG_END  = 3;

endpackage

// File: rtl/letter_sequencer_message_rom.sv
// message_rom: combinational message table.
// Ports:
//   msgId - message identifier
//   len   - number of letters shown, clipped to NUM_SLOTS
//   codes - per-slot letter codes; slots past the message are LETTER_BLANK
module message_rom
    import letter_sequencer_pkg::*;
#(
    parameter int NUM_SLOTS = 8,
    parameter int IDW       = 2
) (
    input  logic [IDW-1:0]            msgId,
    output logic [4:0]                len,
    output logic [NUM_SLOTS-1:0][3:0] codes
);

    localparam logic [4:0] SLOTS5 = 5'(NUM_SLOTS);

    logic [4:0]                   rawLen;
    logic [MSG_MAX_LEN-1:0][3:0] txt;

    always_comb begin
        rawLen = 5'd0;
        txt    = {MSG_MAX_LEN{LETTER_BLANK}};
        case (int'(msgId))
            MSG_HIGH: begin
                rawLen = 5'd4;
                txt[0] = LTR_H; txt[1] = LTR_I; txt[2] = LTR_G; txt[3] = LTR_H;
            end
            MSG_OK: begin
                rawLen = 5'd2;
                txt[0] = LTR_O; txt[1] = LTR_K;
            end
            MSG_GAME: begin
                rawLen = 5'd4;
                txt[0] = LTR_G; txt[1] = LTR_A; txt[2] = LTR_M; txt[3] = LTR_E;
            end
            MSG_END: begin
                rawLen = 5'd3;
                txt[0] = LTR_E; txt[1] = LTR_N; txt[2] = LTR_D;
            end
            default: ;
        endcase

        len = (rawLen > SLOTS5) ? SLOTS5 : rawLen;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            codes[i] = (5'(i) < rawLen) ? txt[i] : LETTER_BLANK;
        end
    end

endmodule

// File: rtl/letter_sequencer.sv
// letter_sequencer: arbitrates message requests and types the granted message
// onto a row of letter renderers, then blinks it and clears the display.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   startOfFrame   - one-cycle pulse per video frame
//   msgReq         - request pulses, bit i requests message i
//   msgGrant       - one-hot grant pulse
//   msgBusy        - high whenever the sequencer is not IDLE
//   msgDone        - pulse when a message completes normally
//   slotLetter     - letter code per slot (blank when disabled)
//   slotEnable     - draw enable per slot
//
// state  | meaning
// IDLE   | display clear, waiting for a pending request
// LOAD   | latch length and letters of the granted message
// REVEAL | enable one slot every REVEAL_FRAMES frames
// HOLD   | whole message shown, blinking, for HOLD_FRAMES frames
module letter_sequencer
    import letter_sequencer_pkg::*;
#(
    parameter int NUM_SLOTS     = 8,
    parameter int NUM_MSG       = 4,
    parameter int REVEAL_FRAMES = 4,
    parameter int HOLD_FRAMES   = 120,
    parameter int BLINK_FRAMES  = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      startOfFrame,
    input  logic [NUM_MSG-1:0]        msgReq,
    output logic [NUM_MSG-1:0]        msgGrant,
    output logic                      msgBusy,
    output logic                      msgDone,
    output logic [NUM_SLOTS-1:0][3:0] slotLetter,
    output logic [NUM_SLOTS-1:0]      slotEnable
);

    localparam int IDW  = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;
    localparam int FMAX = (REVEAL_FRAMES > HOLD_FRAMES) ? REVEAL_FRAMES : HOLD_FRAMES;
    localparam int FW   = $clog2(FMAX + 1);
    localparam int BW   = $clog2(BLINK_FRAMES + 1);
    localparam logic [FW-1:0] REVEAL_LAST = FW'(REVEAL_FRAMES - 1);
    localparam logic [FW-1:0] HOLD_LAST   = FW'(HOLD_FRAMES - 1);
    localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_FRAMES - 1);

    seq_state_t                state, stateNext;
    logic [NUM_MSG-1:0]        pend, pendNext, reqAll, grantNext;
    logic [IDW-1:0]            activeId, activeIdNext, grantId;
    logic [4:0]                len, lenNext, romLen;
    logic [4:0]                revealCnt, revealCntNext;
    logic [FW-1:0]             frameCnt, frameCntNext;
    logic [BW-1:0]             blinkCnt, blinkCntNext;
    logic [NUM_SLOTS-1:0][3:0] letters, lettersNext, romCodes, slotLetterNext;
    logic [NUM_SLOTS-1:0]      enMask, enMaskNext, slotEnableNext;
    logic                      vis, visNext, doneNext, found;

    message_rom #(.NUM_SLOTS(NUM_SLOTS), .IDW(IDW)) u_rom (
        .msgId (activeId),
        .len   (romLen),
        .codes (romCodes)
    );

    // Arbitration looks at pend|msgReq so the grant register is loaded in the
    // request cycle; the FSM acts on the registered grant one cycle later.
    // In REVEAL/HOLD only ids above the active one in priority may preempt.
    always_comb begin
        reqAll    = pend | msgReq;
        grantNext = '0;
        found     = 1'b0;
        if (msgGrant == '0 && state != LOAD) begin
            for (int i = 0; i < NUM_MSG; i++) begin
                if (!found && reqAll[i] && (state == IDLE || IDW'(i) < activeId)) begin
                    grantNext[i] = 1'b1;
                    found        = 1'b1;
                end
            end
        end
        grantId = '0;
        for (int i = 0; i < NUM_MSG; i++) begin
            if (msgGrant[i]) grantId = IDW'(i);
        end
    end

    always_comb begin
        stateNext     = state;
        pendNext      = (pend & ~msgGrant) | msgReq;
        activeIdNext  = activeId;
        lenNext       = len;
        lettersNext   = letters;
        enMaskNext    = enMask;
        visNext       = vis;
        revealCntNext = revealCnt;
        frameCntNext  = frameCnt;
        blinkCntNext  = blinkCnt;
        doneNext      = 1'b0;

        if (msgGrant != '0) begin
            // Grant cycle: new or preempting message; the old one is dropped.
            stateNext    = LOAD;
            activeIdNext = grantId;
            enMaskNext   = '0;
        end else begin
            case (state)
                IDLE: ;
                LOAD: begin
                    lenNext       = romLen;
                    lettersNext   = romCodes;
                    revealCntNext = '0;
                    frameCntNext  = '0;
                    blinkCntNext  = '0;
                    enMaskNext    = '0;
                    visNext       = 1'b1;
                    stateNext     = REVEAL;
                end
                REVEAL: begin
                    if (len == 5'd0) begin
                        stateNext    = HOLD;
                        frameCntNext = '0;
                        blinkCntNext = '0;
                    end else if (startOfFrame) begin
                        if (frameCnt == REVEAL_LAST) begin
                            for (int i = 0; i < NUM_SLOTS; i++) begin
                                if (5'(i) == revealCnt) enMaskNext[i] = 1'b1;
                            end
                            revealCntNext = revealCnt + 5'd1;
                            frameCntNext  = '0;
                            if (revealCnt + 5'd1 >= len) begin
                                stateNext    = HOLD;
                                blinkCntNext = '0;
                            end
                        end else begin
                            frameCntNext = frameCnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (startOfFrame) begin
                        if (frameCnt == HOLD_LAST) begin
                            doneNext   = 1'b1;
                            enMaskNext = '0;
                            stateNext  = IDLE;
                        end else begin
                            frameCntNext = frameCnt + 1'b1;
                            if (blinkCnt == BLINK_LAST) begin
                                visNext      = ~vis;
                                blinkCntNext = '0;
                            end else begin
                                blinkCntNext = blinkCnt + 1'b1;
                            end
                        end
                    end
                end
                default: stateNext = IDLE;
            endcase
        end

        slotEnableNext = enMaskNext & {NUM_SLOTS{visNext}};
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slotLetterNext[i] = slotEnableNext[i] ? lettersNext[i] : LETTER_BLANK;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pend       <= '0;
            activeId   <= '0;
            len        <= '0;
            letters    <= {NUM_SLOTS{LETTER_BLANK}};
            enMask     <= '0;
            vis        <= 1'b1;
            revealCnt  <= '0;
            frameCnt   <= '0;
            blinkCnt   <= '0;
            msgGrant   <= '0;
            msgBusy    <= 1'b0;
            msgDone    <= 1'b0;
            slotEnable <= '0;
            slotLetter <= {NUM_SLOTS{LETTER_BLANK}};
        end else begin
            state      <= stateNext;
            pend       <= pendNext;
            activeId   <= activeIdNext;
            len        <= lenNext;
            letters    <= lettersNext;
            enMask     <= enMaskNext;
            vis        <= visNext;
            revealCnt  <= revealCntNext;
            frameCnt   <= frameCntNext;
            blinkCnt   <= blinkCntNext;
            msgGrant   <= grantNext;
            msgBusy    <= (stateNext != IDLE);
            msgDone    <= doneNext;
            slotEnable <= slotEnableNext;
            slotLetter <= slotLetterNext;
        end
    end

endmodule

// File: tb/tb_letter_sequencer.sv
// Self-checking bench for letter_sequencer: grant/done scoreboard plus
// timed checks of reveal, blink, preemption, replay and reset.
module tb_letter_sequencer;

    localparam int NS        = 8;
    localparam int NM        = 4;
    localparam int FRAME_CYC = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              startOfFrame;
    logic [NM-1:0]     msgReq;
    logic [NM-1:0]     msgGrant;
    logic              msgBusy;
    logic              msgDone;
    logic [NS-1:0][3:0] slotLetter;
    logic [NS-1:0]     slotEnable;

    int nTests = 0;
    int nFail  = 0;
    int grantQ[$];
    int doneQ[$];
    int lastId = -1;

    letter_sequencer #(
        .NUM_SLOTS(NS), .NUM_MSG(NM), .REVEAL_FRAMES(4),
        .HOLD_FRAMES(120), .BLINK_FRAMES(15)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (startOfFrame),
        .msgReq       (msgReq),
        .msgGrant     (msgGrant),
        .msgBusy      (msgBusy),
        .msgDone      (msgDone),
        .slotLetter   (slotLetter),
        .slotEnable   (slotEnable)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected glyph codes: HIGH, OK, GAME, END.
    function automatic logic [3:0] txt(int id, int s);
        logic [3:0] c;
        c = 4'hF;
        case (id)
            0: case (s) 0: c = 4'd7;  1: c = 4'd8;  2: c = 4'd6;  3: c = 4'd7; default: ; endcase
            1: case (s) 0: c = 4'd14; 1: c = 4'd10; default: ; endcase
            2: case (s) 0: c = 4'd6;  1: c = 4'd0;  2: c = 4'd12; 3: c = 4'd4; default: ; endcase
            3: case (s) 0: c = 4'd4;  1: c = 4'd13; 2: c = 4'd3; default: ; endcase
            default: ;
        endcase
        return c;
    endfunction

    function automatic logic [31:0] expLetters(int id, logic [NS-1:0] mask);
        logic [31:0] r;
        r = '1;
        for (int s = 0; s < NS; s++) begin
            if (mask[s]) r[s*4 +: 4] = txt(id, s);
        end
        return r;
    endfunction

    task automatic chk_slots(input string tag, input int id, input logic [NS-1:0] mask);
        chk({tag, "_en"}, slotEnable, mask);
        chk({tag, "_ltr"}, slotLetter, expLetters(id, mask));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_en"}, slotEnable, 0);
        chk({tag, "_ltr"}, slotLetter, 32'hFFFF_FFFF);
        chk({tag, "_busy"}, msgBusy, 0);
        chk({tag, "_grant"}, msgGrant, 0);
        chk({tag, "_done"}, msgDone, 0);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        cyc(1);
        startOfFrame = 1'b0;
        cyc(FRAME_CYC - 1);
    endtask

    task automatic run_frames(input int n);
        repeat (n) frame();
    endtask

    task automatic req(input logic [NM-1:0] bits);
        msgReq = bits;
        cyc(1);
        msgReq = '0;
    endtask

    // Final hold frame: done pulse, enables cleared, then one cycle later.
    task automatic done_frame(input string tag);
        startOfFrame = 1'b1;
        cyc(1);
        startOfFrame = 1'b0;
        chk({tag, "_done"}, msgDone, 1);
        chk({tag, "_clr"}, slotEnable, 0);
        chk({tag, "_idle"}, msgBusy, 0);
        cyc(1);
        chk({tag, "_done_once"}, msgDone, 0);
    endtask

    // Scoreboard: every grant and done pulse must match the next expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (msgGrant != '0) begin
                if (grantQ.size() == 0) begin
                    chk("unexpected_grant", msgGrant, 0);
                end else begin
                    int e;
                    e = grantQ.pop_front();
                    chk("grant_sb", msgGrant, 64'(1) << e);
                    lastId = e;
                end
            end
            if (msgDone) begin
                if (doneQ.size() == 0) begin
                    chk("unexpected_done", msgDone, 0);
                end else begin
                    int e;
                    e = doneQ.pop_front();
                    chk("done_sb_id", lastId, e);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", nTests, nFail + 1);
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        startOfFrame = 1'b0;
        msgReq       = '0;
        cyc(3);
        reset = 1'b0;
        run_frames(5);
        chk_reset_vals("t1_idle");

        // Message 1 (len 2): grant latency, LOAD ignores frame, reveal, blink, done.
        grantQ.push_back(1);
        req(4'b0010);
        chk("t2_grant", msgGrant, 4'b0010);
        chk("t2_busy_grant", msgBusy, 0);
        cyc(1);
        chk("t2_busy_load", msgBusy, 1);
        startOfFrame = 1'b1;
        cyc(1);
        startOfFrame = 1'b0;
        cyc(FRAME_CYC - 1);
        run_frames(3);
        chk_slots("t2_f3", 1, 8'b00);
        frame();
        chk_slots("t2_f4", 1, 8'b01);
        run_frames(4);
        chk_slots("t2_f8", 1, 8'b11);
        run_frames(14);
        chk_slots("t2_h14", 1, 8'b11);
        frame();
        chk_slots("t2_h15", 1, 8'b00);
        run_frames(15);
        chk_slots("t2_h30", 1, 8'b11);
        run_frames(89);
        chk("t2_busy_h119", msgBusy, 1);
        chk("t2_nodone_h119", msgDone, 0);
        doneQ.push_back(1);
        done_frame("t2");

        // Simultaneous requests 0 and 3: 0 first, 3 right after 0 completes.
        run_frames(2);
        grantQ.push_back(0);
        grantQ.push_back(3);
        req(4'b1001);
        chk("t3_grant0", msgGrant, 4'b0001);
        cyc(2);
        run_frames(16);
        chk_slots("t3_m0_full", 0, 8'b1111);
        run_frames(119);
        doneQ.push_back(0);
        done_frame("t3_m0");
        chk("t3_grant3", msgGrant, 4'b1000);
        cyc(2);
        run_frames(12);
        chk_slots("t3_m3_full", 3, 8'b111);
        run_frames(119);
        doneQ.push_back(3);
        done_frame("t3_m3");

        // Message 2 preempted by message 0 after its first reveal.
        run_frames(1);
        grantQ.push_back(2);
        req(4'b0100);
        chk("t4_grant2", msgGrant, 4'b0100);
        cyc(2);
        run_frames(4);
        chk_slots("t4_rev1", 2, 8'b0001);
        grantQ.push_back(0);
        req(4'b0001);
        chk("t4_preempt", msgGrant, 4'b0001);
        cyc(1);
        chk("t4_load_clr", slotEnable, 0);
        chk("t4_load_busy", msgBusy, 1);
        cyc(1);
        run_frames(16 + 119);
        doneQ.push_back(0);
        done_frame("t4_m0");
        run_frames(3);
        chk("t4_no_replay", msgBusy, 0);

        // Message 1 re-requested during HOLD is replayed from slot 0.
        grantQ.push_back(1);
        req(4'b0010);
        chk("t5_grant", msgGrant, 4'b0010);
        cyc(2);
        run_frames(8 + 10);
        grantQ.push_back(1);
        req(4'b0010);
        chk("t5_rereq_wait", msgGrant, 0);
        run_frames(109);
        doneQ.push_back(1);
        done_frame("t5");
        chk("t5_replay_grant", msgGrant, 4'b0010);
        cyc(2);
        chk_slots("t5_replay_start", 1, 8'b00);
        run_frames(4);
        chk_slots("t5_replay_s0", 1, 8'b01);
        run_frames(4 + 3);

        // Reset mid-HOLD with message 2 pending: silent abort, nothing granted.
        req(4'b0100);
        chk("t6_no_preempt", msgGrant, 0);
        cyc(2);
        reset = 1'b1;
        cyc(1);
        chk_reset_vals("t6_reset");
        reset = 1'b0;
        run_frames(5);
        chk_reset_vals("t6_after");
        chk("t6_grantq_empty", grantQ.size(), 0);
        chk("t6_doneq_empty", doneQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/letter_sequencer.md
# letter_sequencer

Controller in front of the row of `letter` glyph renderers that arbitrates between game-event message requests and types the granted message onto the display. Each letter slot is revealed one at a time on frame boundaries, the message then blinks for a hold period, and the display is cleared. It drives one 4-bit letter code and one enable per `letter` instance. Its `msgBusy` output lets game logic avoid queuing messages during a display.

## Interface
Parameters:
- `NUM_SLOTS`, 8: number of `letter` instances driven (1..16).
- `NUM_MSG`, 4: number of requesters / messages.
- `REVEAL_FRAMES`, 4: frames between successive slot reveals (>=1).
- `HOLD_FRAMES`, 120: frames the complete message is held (>=1).
- `BLINK_FRAMES`, 15: frames per blink half-period during hold (>=1).

Ports:
- `clk`  in  1: pixel clock; the only clock.
- `reset`  in  1: synchronous, active-high reset.
- `startOfFrame`  in  1: one-cycle pulse per video frame.
- `msgReq`  in  `NUM_MSG`: one-cycle request pulses; bit i requests message i.
- `msgGrant`  out  `NUM_MSG`: one-hot, one-cycle pulse when a message is accepted.
- `msgBusy`  out  1: high in any state other than IDLE.
- `msgDone`  out  1: one-cycle pulse when a message completes normally.
- `slotLetter`  out  `NUM_SLOTS`x4: letter code per slot.
- `slotEnable`  out  `NUM_SLOTS`: per-slot draw enable, ANDed with that slot's `drawLetter`.

## Operation
- **Pending register.** `pend[NUM_MSG-1:0]` is sticky.
  - Bit i sets on `msgReq[i]`.
  - Bit i clears in the cycle its grant is issued.
  - A set and a clear of the same bit in the same cycle leave the bit set.
- **Priority.** Fixed; index 0 is the highest.
- **States.**
  - IDLE:
    - If `pend != 0`, grant the highest-priority bit and go to LOAD.
    - Otherwise stay.
  - LOAD: one cycle.
    - Latch `len` and the letter codes from `message_rom`.
    - Clear `revealCnt`, `frameCnt` and all enables.
    - Go to REVEAL.
  - REVEAL: on each `startOfFrame`, `frameCnt++`. When `frameCnt == REVEAL_FRAMES-1`:
    - set `slotEnable[revealCnt]`;
    - `revealCnt++`;
    - `frameCnt = 0`.
    - When `revealCnt` reaches `len`, go to HOLD with `frameCnt = 0` and `blinkCnt = 0`.
  - HOLD: on each `startOfFrame`, `frameCnt++` and `blinkCnt++`.
    - When `blinkCnt == BLINK_FRAMES-1`, toggle the visibility of slots `0..len-1` and clear `blinkCnt`.
    - When `frameCnt == HOLD_FRAMES-1`, pulse `msgDone`, clear all enables and go to IDLE.
- **Preemption.** In REVEAL or HOLD, a pending bit with a higher priority than the active message:
  - grants immediately and goes to LOAD;
  - the preempted message is dropped: no `msgDone`, no re-queue.
- **Re-request of the active id.** Only sets its pend bit; that message is replayed after the current one completes.
- **Slot contents.**
  - Slots `>= len` always show `LETTER_BLANK` and stay disabled.
  - Any disabled slot outputs `LETTER_BLANK`.
- **Reset.**
  - State, `pend`, counters and `len` are cleared.
  - `slotEnable = 0`.
  - `slotLetter = LETTER_BLANK` for every slot.
  - `msgGrant = 0`, `msgBusy = 0`, `msgDone = 0`.
  - Reset during any state aborts silently.

## Timing
- **Request to grant.** Request in cycle t with IDLE and empty pend: `pend` is set at t+1 and `msgGrant` pulses at t+1.
- **State after grant.** LOAD at t+2, REVEAL at t+3.
- **Frame gating.** All counters advance only on `startOfFrame`. A frame pulse arriving during LOAD is ignored.
- **First reveal.** Slot 0 enables on the REVEAL_FRAMES-th `startOfFrame` seen in REVEAL. The enable is registered and visible the next cycle.
- **Full visibility.** The entire message is visible `len*REVEAL_FRAMES` frames after entering REVEAL.
- **Done timing.** `msgDone` and enable-clear occur in the same cycle; the state is IDLE the next cycle.
- **Back-to-back.** A new grant can come from IDLE one cycle after `msgDone`.
- **Registered outputs.** All outputs are registered, so there is no combinational path from `msgReq`.

## Structure
- **Shared defines package:**
  - `LETTER_BLANK` (4'hF);
  - the letter code enum (A=0, B=1, …);
  - the `seq_state_t` enum {IDLE, LOAD, REVEAL, HOLD};
  - message ids as named constants.
- **Sub-module `message_rom`.** Combinational case on message id, returning `len[4:0]` and `NUM_SLOTS`x4 codes. Unused codes are `LETTER_BLANK`.
- **Arbiter.** The priority encoder stays inline; it is small.

## Test plan
- Reset, then idle 5 frames -> all outputs at reset values, `msgBusy = 0`.
- `msgReq = 4'b0010`, message 1 with `len = 2` (`REVEAL_FRAMES = 4`) -> `msgGrant = 4'b0010` one cycle later.
  - `slotEnable = 01` after the 4th frame, `11` after the 8th.
  - Blink toggles every 15 frames.
  - `msgDone` after 120 hold frames, then enables return to 0.
- `msgReq = 4'b1001` in the same cycle -> message 0 granted first. Message 3 is granted one cycle after message 0's `msgDone`.
- Message 2 in REVEAL with `revealCnt = 1`, then request 0 -> immediate grant 0, enables cleared in LOAD, no `msgDone` for message 2, message 2 not replayed.
- Active message 1 re-requested during HOLD -> message 1 is replayed from slot 0 after `msgDone`.
- Reset asserted mid-HOLD with `pend = 4'b0100` -> next cycle all outputs at reset values and `pend = 0`; nothing is granted afterwards.
